// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multi-cycle control FSM: opcodes, state codes and
// the datapath select encodings.
package mc_ctrl_pkg;

    localparam logic [5:0] OpR    = 6'b000000;
    localparam logic [5:0] OpLw   = 6'b100011;
    localparam logic [5:0] OpSw   = 6'b101011;
    localparam logic [5:0] OpBeq  = 6'b000100;
    localparam logic [5:0] OpAddi = 6'b001000;
    localparam logic [5:0] OpJ    = 6'b000010;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAddr  = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExec     = 4'd6,
        StRWb      = 4'd7,
        StBranch   = 4'd8,
        StJump     = 4'd9,
        StIExec    = 4'd10,
        StIWb      = 4'd11
    } state_e;

    localparam logic [1:0] AluAdd   = 2'b00;
    localparam logic [1:0] AluSub   = 2'b01;
    localparam logic [1:0] AluFunct = 2'b10;

    localparam logic [1:0] SrcBReg   = 2'b00;
    localparam logic [1:0] SrcBFour  = 2'b01;
    localparam logic [1:0] SrcBImm   = 2'b10;
    localparam logic [1:0] SrcBImmSh = 2'b11;

    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational control-word decoder: current state plus opcode and status
// inputs give the datapath controls, the next state and the retire strobe.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [3:0] next_state,
    output logic       retire,
    output logic       pc_ce,
    output logic       ir_ce,
    output logic       mdr_ce,
    output logic       ab_ce,
    output logic       aluout_ce,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op
);

    always_comb begin
        next_state = StFetch;
        retire     = 1'b0;
        pc_ce      = 1'b0;
        ir_ce      = 1'b0;
        mdr_ce     = 1'b0;
        ab_ce      = 1'b0;
        aluout_ce  = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SrcBReg;
        alu_op     = AluAdd;
        pc_source  = PcSrcAlu;
        illegal_op = 1'b0;

        case (state)
            StFetch: begin
                mem_read   = 1'b1;
                alu_src_b  = SrcBFour;
                ir_ce      = mem_ready;
                pc_ce      = mem_ready;
                next_state = mem_ready ? StDecode : StFetch;
            end
            StDecode: begin
                // ALUOut captures PC + (imm << 2) as the speculative branch target.
                ab_ce     = 1'b1;
                aluout_ce = 1'b1;
                alu_src_b = SrcBImmSh;
                case (op)
                    OpLw, OpSw: next_state = StMemAddr;
                    OpR:        next_state = StExec;
                    OpBeq:      next_state = StBranch;
                    OpJ:        next_state = StJump;
                    OpAddi:     next_state = StIExec;
                    default: begin
                        illegal_op = 1'b1;
                        next_state = StFetch;
                    end
                endcase
            end
            StMemAddr: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SrcBImm;
                aluout_ce  = 1'b1;
                next_state = (op == OpSw) ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                mem_read   = 1'b1;
                iord       = 1'b1;
                mdr_ce     = mem_ready;
                next_state = mem_ready ? StMemWb : StMemRead;
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
            end
            StMemWrite: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                retire     = mem_ready;
                next_state = mem_ready ? StFetch : StMemWrite;
            end
            StExec: begin
                alu_src_a  = 1'b1;
                alu_op     = AluFunct;
                aluout_ce  = 1'b1;
                next_state = StRWb;
            end
            StRWb: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
            end
            StBranch: begin
                alu_src_a = 1'b1;
                alu_op    = AluSub;
                pc_source = PcSrcAluOut;
                pc_ce     = zero;
                retire    = 1'b1;
            end
            StJump: begin
                pc_source = PcSrcJump;
                pc_ce     = 1'b1;
                retire    = 1'b1;
            end
            StIExec: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SrcBImm;
                aluout_ce  = 1'b1;
                next_state = StIWb;
            end
            StIWb: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Main control FSM for the multi-cycle datapath: holds the state register and
// retired-instruction counter, and masks all enables and strobes during reset.
module multi_cycle_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  op,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_ce,
    output logic        ir_ce,
    output logic        mdr_ce,
    output logic        ab_ce,
    output logic        aluout_ce,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        reg_dst,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_source,
    output logic        illegal_op,
    output logic [31:0] instr_cnt,
    output logic [3:0]  state
);

    logic [3:0]  state_q;
    logic [3:0]  state_d;
    logic [31:0] instr_cnt_q;
    logic        retire;
    logic        dec_pc_ce;
    logic        dec_ir_ce;
    logic        dec_mdr_ce;
    logic        dec_ab_ce;
    logic        dec_aluout_ce;
    logic        dec_mem_read;
    logic        dec_mem_write;
    logic        dec_reg_write;
    logic        dec_illegal_op;

    mc_ctrl_decode u_decode (
        .state      (state_q),
        .op         (op),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .next_state (state_d),
        .retire     (retire),
        .pc_ce      (dec_pc_ce),
        .ir_ce      (dec_ir_ce),
        .mdr_ce     (dec_mdr_ce),
        .ab_ce      (dec_ab_ce),
        .aluout_ce  (dec_aluout_ce),
        .iord       (iord),
        .mem_read   (dec_mem_read),
        .mem_write  (dec_mem_write),
        .mem_to_reg (mem_to_reg),
        .reg_dst    (reg_dst),
        .reg_write  (dec_reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_source  (pc_source),
        .illegal_op (dec_illegal_op)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StFetch;
            instr_cnt_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                instr_cnt_q <= instr_cnt_q + 32'd1;
            end
        end
    end

    // Reset masks anything that could disturb datapath or memory state.
    assign pc_ce      = dec_pc_ce      & ~rst;
    assign ir_ce      = dec_ir_ce      & ~rst;
    assign mdr_ce     = dec_mdr_ce     & ~rst;
    assign ab_ce      = dec_ab_ce      & ~rst;
    assign aluout_ce  = dec_aluout_ce  & ~rst;
    assign mem_read   = dec_mem_read   & ~rst;
    assign mem_write  = dec_mem_write  & ~rst;
    assign reg_write  = dec_reg_write  & ~rst;
    assign illegal_op = dec_illegal_op & ~rst;

    assign instr_cnt = instr_cnt_q;
    assign state     = state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: state traces, gated enables, stalls,
// illegal opcode and mid-instruction reset against hand-computed values.
module tb_multi_cycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  op;
    logic        zero;
    logic        mem_ready;
    logic        pc_ce, ir_ce, mdr_ce, ab_ce, aluout_ce, iord;
    logic        mem_read, mem_write, mem_to_reg, reg_dst, reg_write;
    logic        alu_src_a, illegal_op;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [31:0] instr_cnt;
    logic [3:0]  state;

    int n_vec = 0;
    int n_err = 0;

    multi_cycle_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_ce      (pc_ce),
        .ir_ce      (ir_ce),
        .mdr_ce     (mdr_ce),
        .ab_ce      (ab_ce),
        .aluout_ce  (aluout_ce),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_to_reg (mem_to_reg),
        .reg_dst    (reg_dst),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_source  (pc_source),
        .illegal_op (illegal_op),
        .instr_cnt  (instr_cnt),
        .state      (state)
    );

    always #5 clk = ~clk;

    logic [8:0] en;
    assign en = {pc_ce, ir_ce, mdr_ce, ab_ce, aluout_ce, reg_write, mem_read, mem_write,
                 illegal_op};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Walk one instruction: seq holds state codes, first cycle in the low nibble.
    task automatic run(input string tag, input logic [5:0] o, input logic z, input int n,
                       input logic [19:0] seq);
        logic [3:0] s;
        op   = o;
        zero = z;
        #1;
        for (int i = 0; i < n; i++) begin
            s = seq[4*i +: 4];
            chk($sformatf("%s_st%0d", tag, i), {28'd0, state}, {28'd0, s});
            if (s == 4'd8) begin
                chk({tag, "_br_pcce"}, {31'd0, pc_ce}, {31'd0, z});
                chk({tag, "_br_pcsrc"}, {30'd0, pc_source}, 32'd1);
            end
            if (s == 4'd9) begin
                chk({tag, "_j_pcce"}, {31'd0, pc_ce}, 32'd1);
                chk({tag, "_j_pcsrc"}, {30'd0, pc_source}, 32'd2);
            end
            if (s == 4'd4) chk({tag, "_wb_rw_m2r"}, {30'd0, reg_write, mem_to_reg}, 32'd3);
            tick();
        end
    endtask

    initial begin
        rst       = 1'b1;
        op        = 6'b000000;
        zero      = 1'b0;
        mem_ready = 1'b1;

        // Reset held for two edges
        tick();
        chk("rst1_en", {23'd0, en}, 32'd0);
        chk("rst1_state", {28'd0, state}, 32'd0);
        chk("rst1_cnt", instr_cnt, 32'd0);
        tick();
        chk("rst2_en", {23'd0, en}, 32'd0);
        chk("rst2_cnt", instr_cnt, 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_fetch", {29'd0, mem_read, ir_ce, pc_ce}, 32'h7);

        run("lw",   6'b100011, 1'b0, 5, 20'h43210);
        chk("cnt_lw", instr_cnt, 32'd1);
        run("sw",   6'b101011, 1'b0, 4, 20'h05210);
        run("r",    6'b000000, 1'b0, 4, 20'h07610);
        run("addi", 6'b001000, 1'b0, 4, 20'h0BA10);
        run("beq1", 6'b000100, 1'b1, 3, 20'h00810);
        run("j",    6'b000010, 1'b0, 3, 20'h00910);
        chk("cnt_six", instr_cnt, 32'd6);
        chk("back_fetch", {28'd0, state}, 32'd0);

        run("beq0", 6'b000100, 1'b0, 3, 20'h00810);
        chk("cnt_beq0", instr_cnt, 32'd7);

        // LW with 3 stall cycles in FETCH and 2 in MEM_READ: 10 cycles total
        op        = 6'b100011;
        mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("stf_state", {28'd0, state}, 32'd0);
            chk("stf_en", {29'd0, ir_ce, pc_ce, mem_read}, 32'd1);
            chk("stf_iord", {31'd0, iord}, 32'd0);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        chk("stf_ready", {29'd0, ir_ce, pc_ce, mem_read}, 32'h7);
        tick();
        chk("stl_dec", {28'd0, state}, 32'd1);
        tick();
        chk("stl_ma", {28'd0, state}, 32'd2);
        tick();
        mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("stm_state", {28'd0, state}, 32'd3);
            chk("stm_en", {29'd0, mdr_ce, iord, mem_read}, 32'd3);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        chk("stm_ready", {29'd0, mdr_ce, iord, mem_read}, 32'h7);
        tick();
        chk("stl_wb", {28'd0, state}, 32'd4);
        tick();
        chk("stl_done", {28'd0, state}, 32'd0);
        chk("cnt_stall", instr_cnt, 32'd8);

        // Illegal opcode
        op = 6'b111111;
        tick();
        chk("ill_state", {28'd0, state}, 32'd1);
        chk("ill_pulse", {31'd0, illegal_op}, 32'd1);
        tick();
        chk("ill_next", {28'd0, state}, 32'd0);
        chk("ill_clear", {31'd0, illegal_op}, 32'd0);
        chk("ill_cnt", instr_cnt, 32'd8);

        // Reset during MEM_READ aborts the load
        op = 6'b100011;
        tick();
        tick();
        tick();
        chk("ab_state", {28'd0, state}, 32'd3);
        rst = 1'b1;
        #1;
        chk("ab_forced", {23'd0, en}, 32'd0);
        tick();
        chk("ab_rst_state", {28'd0, state}, 32'd0);
        chk("ab_no_rw", {31'd0, reg_write}, 32'd0);
        chk("ab_cnt", instr_cnt, 32'd0);
        rst = 1'b0;
        #1;
        chk("ab_fetch", {29'd0, mem_read, ir_ce, pc_ce}, 32'h7);
        tick();
        chk("ab_dec", {28'd0, state}, 32'd1);
        chk("ab_cnt2", instr_cnt, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multi_cycle_ctrl.md
# multi_cycle_ctrl

Main control FSM for the multi-cycle datapath. Sequences the 32-bit datapath registers (PC, IR, MDR, A/B, ALUOut) by driving their clock-enable inputs. Also drives the datapath mux selects, ALU operation class, register-file write and memory strobes for the six-instruction subset. Sits beside the datapath and takes the opcode, ALU zero flag and memory ready as inputs.

## Interface
Parameters:
- none; opcodes and state codes are fixed constants in the shared package.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- op  in  6  IR[31:26]
- zero  in  1  ALU zero flag, valid in BRANCH
- mem_ready  in  1  memory access completes this cycle
- pc_ce  out  1  PC register CE
- ir_ce  out  1  IR register CE
- mdr_ce  out  1  MDR register CE
- ab_ce  out  1  A and B register CE
- aluout_ce  out  1  ALUOut register CE
- iord  out  1  memory address source: 0 = PC, 1 = ALUOut
- mem_read, mem_write  out  1 each  memory strobes
- mem_to_reg  out  1  write-back data: 0 = ALUOut, 1 = MDR
- reg_dst  out  1  destination register: 0 = rt, 1 = rd
- reg_write  out  1  register-file write enable
- alu_src_a  out  1  ALU A input: 0 = PC, 1 = A
- alu_src_b  out  2  ALU B input: 00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2
- alu_op  out  2  00 = add, 01 = sub, 10 = decode funct
- pc_source  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- illegal_op  out  1  one-cycle pulse in DECODE for an unknown opcode
- instr_cnt  out  32  count of retired instructions
- state  out  4  current state, for debug

## Operation
- Opcodes: R 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010.
- States and encodings:
  - FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_READ = 3, MEM_WB = 4, MEM_WRITE = 5
  - EXEC = 6, R_WB = 7, BRANCH = 8, JUMP = 9, I_EXEC = 10, I_WB = 11
- FETCH:
  - mem_read = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00.
  - ir_ce and pc_ce are asserted only when mem_ready = 1.
  - Next state: DECODE when mem_ready = 1, else stay in FETCH.
- DECODE:
  - ab_ce = 1, aluout_ce = 1, alu_src_a = 0, alu_src_b = 11, alu_op = 00 (precomputes the branch target).
  - Next state by op: LW/SW → MEM_ADDR, R → EXEC, BEQ → BRANCH, J → JUMP, ADDI → I_EXEC.
  - Any other op: illegal_op = 1 and next state is FETCH. The instruction is not counted.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 10, alu_op = 00, aluout_ce = 1. Next: LW → MEM_READ, SW → MEM_WRITE.
- MEM_READ:
  - mem_read = 1, iord = 1.
  - mdr_ce = 1 only when mem_ready = 1.
  - Hold in this state until mem_ready = 1, then go to MEM_WB.
- MEM_WB: reg_write = 1, mem_to_reg = 1, reg_dst = 0. Retires the instruction; next FETCH.
- MEM_WRITE:
  - mem_write = 1, iord = 1.
  - Hold in this state until mem_ready = 1; retires the instruction on that cycle, then FETCH.
- EXEC: alu_src_a = 1, alu_src_b = 00, alu_op = 10, aluout_ce = 1. Next R_WB.
- R_WB: reg_write = 1, reg_dst = 1, mem_to_reg = 0. Retires; next FETCH.
- BRANCH:
  - alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_source = 01.
  - pc_ce = zero.
  - Retires; next FETCH.
- JUMP: pc_source = 10, pc_ce = 1. Retires; next FETCH.
- I_EXEC: alu_src_a = 1, alu_src_b = 10, alu_op = 00, aluout_ce = 1. Next I_WB.
- I_WB: reg_write = 1, reg_dst = 0, mem_to_reg = 0. Retires; next FETCH.
- Any output not listed for a state is 0 in that state.
- Unused state codes 12–15 go to FETCH on the next edge with all enables at 0.
- instr_cnt increments by 1 on each retiring cycle and wraps from 0xFFFFFFFF to 0.

## Timing
- Outputs are Moore, decoded from `state`. Exceptions:
  - pc_ce, ir_ce and mdr_ce are also gated by mem_ready, or by zero in BRANCH.
  - illegal_op is also gated by op in DECODE.
- Cycle counts with mem_ready held at 1:
  - LW 5, SW 4, R 4, ADDI 4, BEQ 3, J 3.
  - Illegal opcode: 2 cycles, no retire.
- Each cycle with mem_ready = 0 in FETCH, MEM_READ or MEM_WRITE adds one cycle. Strobes and addresses stay stable while waiting.
- While rst = 1:
  - pc_ce, ir_ce, mdr_ce, ab_ce, aluout_ce, reg_write, mem_read, mem_write and illegal_op are forced to 0.
- On the first rising edge with rst = 1: state = FETCH and instr_cnt = 0.
- Reset in the middle of an instruction aborts it with no retire. The first cycle after rst falls is FETCH.

## Structure
- Package `mc_ctrl_pkg` holds:
  - opcode localparams
  - the 4-bit state enum/constants
  - alu_op, alu_src_b and pc_source code constants
- One sub-module, `mc_ctrl_decode`: combinational state+op → control-word decoder. The FSM register and instr_cnt stay in the top module.

## Test plan
- Hold rst = 1 for 2 cycles with mem_ready = 1: all enables 0, state = 0, instr_cnt = 0. After release, the first cycle shows mem_read = 1, ir_ce = 1, pc_ce = 1.
- Send LW, SW, R, ADDI, BEQ (zero = 1) and J with mem_ready = 1:
  - State traces are 0-1-2-3-4, 0-1-2-5, 0-1-6-7, 0-1-10-11, 0-1-8 (pc_ce = 1, pc_source = 01) and 0-1-9 (pc_ce = 1, pc_source = 10).
  - instr_cnt = 6 at the end.
- BEQ with zero = 0: pc_ce = 0 in BRANCH, instr_cnt still increments.
- LW with mem_ready low for 3 cycles in FETCH and 2 cycles in MEM_READ: total 10 cycles. ir_ce and mdr_ce pulse only on their ready cycles.
- op = 111111: illegal_op pulses in DECODE, the next state is FETCH, instr_cnt is unchanged.
- Assert rst in MEM_READ: state goes to 0 on the next edge, no reg_write occurs, instr_cnt goes to 0.
